// File: rtl/time_disp_pkg.sv
// Shared definitions for the six-digit time display scanner:
// FSM states, digit count, seven-segment patterns and separator positions.
package time_disp_pkg;

  typedef enum logic [1:0] {
    LATCH,
    CONV,
    SCAN
  } state_e;

  localparam int unsigned NUM_DIGITS = 6;

  // Digit indices that carry the decimal point as a field separator
  localparam int unsigned DP_IDX_MIN = 2;
  localparam int unsigned DP_IDX_HR  = 4;

  // Active-high segment patterns for 0..9, bit order gfedcba
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    seg_of = (d < 4'd10) ? SEG_LUT[d] : '0;
  endfunction

endpackage

// File: rtl/time_bcd_conv.sv
// Sequential single-field binary to two-digit BCD converter (subtract-by-10).
// While start is held the field value is consumed directly in the first cycle,
// so a field finishes in tens+1 cycles; done/tens/ones are valid in that cycle.
module time_bcd_conv (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic       busy_q, busy_d;
  logic [5:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic [5:0] cur_rem;
  logic [3:0] cur_tens;
  logic       active;

  // Work on the loaded value first, then on the running remainder
  always_comb begin
    cur_rem  = busy_q ? rem_q : value;
    cur_tens = busy_q ? tens_q : '0;
    active   = start | busy_q;
    done     = active && (cur_rem < 6'd10);
    tens     = cur_tens;
    ones     = cur_rem[3:0];
    busy_d   = 1'b0;
    rem_d    = rem_q;
    tens_d   = tens_q;
    if (active && !done) begin
      busy_d = 1'b1;
      rem_d  = cur_rem - 6'd10;
      tens_d = cur_tens + 4'd1;
    end
  end

  // Converter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      tens_q <= '0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      tens_q <= tens_d;
    end
  end

endmodule

// File: rtl/time_disp_scan.sv
// Multiplexed six-digit seven-segment driver for the 12-hour clock counter.
// Frame: LATCH (snapshot) -> CONV (BCD, secs/mins/hours) -> SCAN (6 digits).
// Optional build macro TIME_DISP_HOUR12_EN: snapshot hours 0 shown as 12.
module time_disp_scan
  import time_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hours,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       frame
);

  localparam int unsigned       DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       fld_q, fld_d;
  logic [3:0]       hrs_q, hrs_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [3:0]       dig_q [NUM_DIGITS];
  logic [3:0]       dig_d [NUM_DIGITS];
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  logic             conv_start, conv_done;
  logic [5:0]       conv_val;
  logic [3:0]       conv_tens, conv_ones;

  // Feed the converter the snapshot field currently being converted
  always_comb begin
    conv_start = (state_q == CONV);
    case (fld_q)
      2'd0:    conv_val = sec_q;
      2'd1:    conv_val = min_q;
      default: conv_val = {2'b00, hrs_q};
    endcase
  end

  time_bcd_conv u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (conv_val),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Next-state, snapshot, digit store and registered output computation
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    fld_d   = fld_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    sec_d   = sec_q;
    dig_d   = dig_q;
    case (state_q)
      LATCH: begin
        sec_d = secs;
        min_d = mins;
`ifdef TIME_DISP_HOUR12_EN
        hrs_d = (hours == 4'd0) ? 4'd12 : hours;
`else
        hrs_d = hours;
`endif
        fld_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        if (conv_done) begin
          dig_d[{fld_q, 1'b0}] = conv_ones;
          dig_d[{fld_q, 1'b1}] = conv_tens;
          if (fld_q == 2'd2) begin
            state_d = SCAN;
            idx_d   = '0;
            div_d   = '0;
          end else begin
            fld_d = fld_q + 2'd1;
          end
        end
      end
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = LATCH;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = LATCH;
    endcase

    // Outputs are computed from the next state so they line up with it
    frame_d = (state_d == LATCH);
    seg_d   = '0;
    an_d    = '0;
    dp_d    = 1'b0;
    if (state_d == SCAN) begin
      seg_d = seg_of(dig_q[idx_d]);
      an_d  = 6'b000001 << idx_d;
      dp_d  = (idx_d == 3'(DP_IDX_MIN)) || (idx_d == 3'(DP_IDX_HR));
    end
  end

  // State registers; reset parks the FSM on the last scan slot so the
  // first edge after release lands in LATCH with frame already asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      div_q   <= DIV_LAST;
      idx_q   <= IDX_LAST;
      fld_q   <= '0;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      dig_q   <= '{default: '0};
      seg_q   <= '0;
      an_q    <= '0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      fld_q   <= fld_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Self-checking bench for time_disp_scan: per-cycle frame model derived from
// decimal arithmetic on the applied time, directed cases plus random frames.
module tb_time_disp_scan;

  localparam int unsigned SD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame;

  int ncomp = 0;
  int nfail = 0;

  logic [6:0] seg_tab [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  time_disp_scan #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst   (rst),
    .hours (hours),
    .mins  (mins),
    .secs  (secs),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed bus packed as {frame, dp, an, seg}
  function automatic logic [31:0] bus();
    return {17'd0, frame, dp, an, seg};
  endfunction

  // Apply a time, then check one full frame cycle by cycle.
  // strict: the frame must start on the very next sample.
  // chg_s >= 0: change secs after the first cycle of digit 1.
  // abort_digit >= 0: assert rst in that digit and return after release.
  task automatic run_frame(input int h, input int m, input int s, input bit strict,
                           input int chg_s, input int abort_digit);
    int hh;
    int lat;
    int d [6];
    bit got;
    logic [31:0] exp;
    hours = 4'(h);
    mins  = 6'(m);
    secs  = 6'(s);
    hh = h;
`ifdef TIME_DISP_HOUR12_EN
    if (hh == 0) hh = 12;
`endif
    d[0] = s % 10;  d[1] = s / 10;
    d[2] = m % 10;  d[3] = m / 10;
    d[4] = hh % 10; d[5] = hh / 10;
    lat = (hh / 10 + 1) + (m / 10 + 1) + (s / 10 + 1);

    got = 1'b0;
    if (strict) begin
      @(negedge clk);
      got = frame;
    end else begin
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        got = frame;
      end
    end
    check($sformatf("latch h%0d m%0d s%0d", h, m, s), bus(), 32'h4000);
    if (!got) return;

    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check($sformatf("conv_blank c%0d", c), bus(), 32'h0);
    end

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < int'(SD); c++) begin
        @(negedge clk);
        exp = {17'd0, 1'b0, 1'((i == 2) || (i == 4)), 6'(1 << i), seg_tab[d[i]]};
        check($sformatf("scan d%0d c%0d", i, c), bus(), exp);
        if (i == 1 && c == 0 && chg_s >= 0) secs = 6'(chg_s);
        if (i == abort_digit && c == 1) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_mid_blank", bus(), 32'h0);
          @(negedge clk);
          check("rst_mid_hold", bus(), 32'h0);
          rst = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin
    int h, m, s;
    rst   = 1'b1;
    hours = 4'd0;
    mins  = 6'd0;
    secs  = 6'd0;

    // Reset held three cycles: everything quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset c%0d", i), bus(), 32'h0);
    end
    rst = 1'b0;

    // Nominal 11:59:58, frame on the first cycle after release
    run_frame(11, 59, 58, 1'b1, -1, -1);
    // Coherence: secs moves to 59 mid-scan, current frame keeps 58
    run_frame(11, 59, 58, 1'b0, 59, -1);
    run_frame(11, 59, 59, 1'b0, -1, -1);
    // Hours zero (12 in the 12-hour build)
    run_frame(0, 0, 0, 1'b0, -1, -1);
    // Out-of-range values are converted, not clamped
    run_frame(15, 63, 0, 1'b0, -1, -1);
    // Reset during digit 3, then a complete fresh frame
    run_frame(3, 25, 47, 1'b0, -1, 3);
    run_frame(3, 25, 47, 1'b1, -1, -1);

    // Random frames, some with out-of-range fields
    for (int k = 0; k < 10; k++) begin
      h = (k % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 11));
      m = (k % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
      s = (k % 5 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
      run_frame(h, m, s, 1'b0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
